// File: rtl/booth_seq_arbiter.sv
// Sequential radix-2 Booth multiplier, one substep per clock, with one shared
// add/subtract datapath time-shared between two round-robin requesters.
module booth_seq_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   res_data,
    output logic                 res_id,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH:0]       accA_q, accA_d;
    logic [WIDTH-1:0]     mulQ_q, mulQ_d;
    logic                 qm1_q, qm1_d;
    logic [WIDTH:0]       mcand_q, mcand_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   resData_q, resData_d;
    logic                 resId_q, resId_d;
    logic                 resValid_q, resValid_d;
    logic                 lastGrant_q, lastGrant_d;

    logic                 grantValid;
    logic                 grantIdx;
    logic [WIDTH:0]       sumA;
    logic [2*WIDTH+1:0]   shifted;
    logic [WIDTH:0]       newA;
    logic [WIDTH-1:0]     newQ;
    logic                 newQm1;
    logic [WIDTH-1:0]     selB;

    // Round-robin: on a tie the requester not served last wins.
    always_comb begin
        grantValid = req0_valid | req1_valid;
        grantIdx   = 1'b0;
        if (req0_valid && req1_valid) begin
            grantIdx = ~lastGrant_q;
        end else begin
            grantIdx = req1_valid;
        end
    end

    assign req0_ready = (state_q == IDLE) && grantValid && !grantIdx;
    assign req1_ready = (state_q == IDLE) && grantValid && grantIdx;

    // One Booth substep: conditional add/sub of M, then arithmetic shift of {A,Q,q_1}.
    always_comb begin
        sumA = accA_q;
        case ({mulQ_q[0], qm1_q})
            2'b01:   sumA = accA_q + mcand_q;
            2'b10:   sumA = accA_q - mcand_q;
            default: sumA = accA_q;
        endcase
        shifted = {sumA[WIDTH], sumA, mulQ_q};
        newA    = shifted[2*WIDTH+1:WIDTH+1];
        newQ    = shifted[WIDTH:1];
        newQm1  = shifted[0];
    end

    assign selB = grantIdx ? req1_b : req0_b;

    always_comb begin
        state_d     = state_q;
        accA_d      = accA_q;
        mulQ_d      = mulQ_q;
        qm1_d       = qm1_q;
        mcand_d     = mcand_q;
        count_d     = count_q;
        resData_d   = resData_q;
        resId_d     = resId_q;
        resValid_d  = resValid_q;
        lastGrant_d = lastGrant_q;
        case (state_q)
            IDLE: begin
                if (grantValid) begin
                    accA_d      = '0;
                    mulQ_d      = grantIdx ? req1_a : req0_a;
                    qm1_d       = 1'b0;
                    mcand_d     = {selB[WIDTH-1], selB};
                    count_d     = '0;
                    resId_d     = grantIdx;
                    lastGrant_d = grantIdx;
                    state_d     = RUN;
                end
            end
            RUN: begin
                accA_d  = newA;
                mulQ_d  = newQ;
                qm1_d   = newQm1;
                count_d = count_q + 1'b1;
                // The product is final once the last substep's shift has happened.
                if (count_q == CW'(WIDTH - 1)) begin
                    resData_d  = {newA[WIDTH-1:0], newQ};
                    resValid_d = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    resValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            accA_q      <= '0;
            mulQ_q      <= '0;
            qm1_q       <= 1'b0;
            mcand_q     <= '0;
            count_q     <= '0;
            resData_q   <= '0;
            resId_q     <= 1'b0;
            resValid_q  <= 1'b0;
            lastGrant_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            accA_q      <= accA_d;
            mulQ_q      <= mulQ_d;
            qm1_q       <= qm1_d;
            mcand_q     <= mcand_d;
            count_q     <= count_d;
            resData_q   <= resData_d;
            resId_q     <= resId_d;
            resValid_q  <= resValid_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    assign res_valid = resValid_q;
    assign res_data  = resData_q;
    assign res_id    = resId_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_booth_seq_arbiter.sv
// Self-checking bench for booth_seq_arbiter: directed timing/corner/fairness/
// backpressure/reset cases plus randomized traffic against a cycle-level model.
module tb_booth_seq_arbiter;

    localparam int WIDTH = 8;

    logic               clk;
    logic               rst_n;
    logic               req0_valid, req1_valid;
    logic               req0_ready, req1_ready;
    logic [WIDTH-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic               res_valid, res_ready;
    logic [2*WIDTH-1:0] res_data;
    logic               res_id;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int retired = 0;

    booth_seq_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: one job in flight; result due WIDTH cycles after
    // acceptance, held until the consumer takes it.
    logic               mBusy, mResValid, mLast, mId;
    int                 mCountdown;
    logic [2*WIDTH-1:0] mData;

    function automatic logic [2*WIDTH-1:0] signedProduct(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[2*WIDTH-1:0];
    endfunction

    always @(negedge clk) begin
        logic eg0, eg1;
        if (!rst_n) begin
            mBusy      = 1'b0;
            mResValid  = 1'b0;
            mLast      = 1'b1;
            mId        = 1'b0;
            mCountdown = 0;
            mData      = '0;
        end else begin
            eg0 = 1'b0;
            eg1 = 1'b0;
            if (!mBusy) begin
                if (req0_valid && req1_valid) begin
                    if (mLast) eg0 = 1'b1;
                    else       eg1 = 1'b1;
                end else if (req0_valid) begin
                    eg0 = 1'b1;
                end else if (req1_valid) begin
                    eg1 = 1'b1;
                end
            end
            checkOutput("model_ready0", 32'(req0_ready), 32'(eg0));
            checkOutput("model_ready1", 32'(req1_ready), 32'(eg1));
            checkOutput("one_ready", 32'(req0_ready & req1_ready), 32'd0);
            checkOutput("model_busy", 32'(busy), 32'(mBusy));
            checkOutput("model_res_valid", 32'(res_valid), 32'(mResValid));
            if (mResValid) begin
                checkOutput("model_res_data", 32'(res_data), 32'(mData));
                checkOutput("model_res_id", 32'(res_id), 32'(mId));
            end
            if (eg0 || eg1) begin
                mId        = eg1;
                mLast      = eg1;
                mData      = eg1 ? signedProduct(req1_a, req1_b) : signedProduct(req0_a, req0_b);
                mBusy      = 1'b1;
                mCountdown = WIDTH;
            end else if (mBusy && !mResValid) begin
                mCountdown--;
                if (mCountdown == 0) mResValid = 1'b1;
            end else if (mResValid && res_ready) begin
                mResValid = 1'b0;
                mBusy     = 1'b0;
                retired++;
            end
        end
    end

    task automatic waitAccept(input int which);
        int n;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if ((which == 0 && req0_ready) || (which == 1 && req1_ready)) break;
            n++;
        end
        if (n >= 100) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        while (!res_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!res_valid) checkOutput("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input int which, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int lat);
        if (which == 0) begin
            req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        waitAccept(which);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        waitResult(lat);
    endtask

    function automatic logic [WIDTH-1:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'hFF;
            3:       return 8'h00;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    typedef struct {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [2*WIDTH-1:0] p;
    } corner_t;

    corner_t corners[5] = '{
        '{8'h80, 8'h80, 16'h4000},
        '{8'h80, 8'h7F, 16'hC080},
        '{8'h7F, 8'h80, 16'hC080},
        '{8'hFF, 8'hFF, 16'h0001},
        '{8'h00, 8'hB3, 16'h0000}
    };

    initial begin
        int lat;
        int ids[4];

        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        res_ready = 1'b1;

        #12;
        checkOutput("reset_res_valid", 32'(res_valid), 32'd0);
        checkOutput("reset_res_data", 32'(res_data), 32'd0);
        checkOutput("reset_res_id", 32'(res_id), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic timing on requester 0
        applyStimulus(0, 8'd3, 8'd5, lat);
        checkOutput("basic_latency", 32'(lat), 32'd8);
        checkOutput("basic_data", 32'(res_data), 32'h000F);
        checkOutput("basic_id", 32'(res_id), 32'd0);
        checkOutput("basic_ready0_done", 32'(req0_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("basic_held_one_cycle", 32'(res_valid), 32'd0);
        checkOutput("basic_idle_busy", 32'(busy), 32'd0);

        // Signed corners through requester 1
        foreach (corners[i]) begin
            applyStimulus(1, corners[i].a, corners[i].b, lat);
            checkOutput("corner_data", 32'(res_data), 32'(corners[i].p));
            checkOutput("corner_id", 32'(res_id), 32'd1);
            @(posedge clk);
            #1;
        end

        // Backpressure with both requesters pending
        res_ready = 1'b0;
        req0_a = 8'hFB; req0_b = 8'd9;  req0_valid = 1'b1;
        req1_a = 8'd11; req1_b = 8'd11; req1_valid = 1'b1;
        waitAccept(0);
        waitResult(lat);
        checkOutput("bp_latency", 32'(lat), 32'd8);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_res_valid", 32'(res_valid), 32'd1);
            checkOutput("bp_res_data", 32'(res_data), 32'hFFD3);
            checkOutput("bp_res_id", 32'(res_id), 32'd0);
            checkOutput("bp_busy", 32'(busy), 32'd1);
            checkOutput("bp_readies", 32'({req0_ready, req1_ready}), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_retired", 32'(res_valid), 32'd0);
        checkOutput("bp_next_grant1", 32'(req1_ready), 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Asynchronous reset in the middle of 6*7
        applyStimulus(0, 8'd6, 8'd7, lat);
        @(posedge clk);
        #1;
        req0_a = 8'd6; req0_b = 8'd7; req0_valid = 1'b1;
        waitAccept(0);
        req0_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_res_valid", 32'(res_valid), 32'd0);
        checkOutput("async_res_data", 32'(res_data), 32'd0);
        checkOutput("async_res_id", 32'(res_id), 32'd0);
        checkOutput("async_busy", 32'(busy), 32'd0);

        // Fairness after reset: both requesters continuously valid
        req0_a = 8'd6; req0_b = 8'd7; req0_valid = 1'b1;
        req1_a = 8'd2; req1_b = 8'hFD; req1_valid = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            waitResult(lat);
            ids[k] = 32'(res_id);
            if (k == 0) checkOutput("post_reset_data", 32'(res_data), 32'h002A);
            if (k == 1) checkOutput("fair_data1", 32'(res_data), 32'hFFFA);
            checkOutput("fair_grant_order", 32'(ids[k]), 32'(k % 2));
            @(posedge clk);
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Randomized traffic, checked cycle by cycle by the model
        retired = 0;
        for (int c = 0; c < 4000; c++) begin
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            req0_a = pickOperand();
            req0_b = pickOperand();
            req1_a = pickOperand();
            req1_b = pickOperand();
            res_ready = ($urandom_range(0, 9) < 6);
            @(posedge clk);
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("random_retired_some", 32'(retired > 50), 32'd1);
        checkOutput("random_final_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
